debug_frame_sender: RTL and testbench

- Upstream feeder for the UART transmit FIFO.
- On a `start` pulse it snapshots the MIPS_DLX debug vector and serializes it into a byte frame: header, data bytes LSB-first, XOR checksum, trailer.
- It writes the frame through the FIFO's wr/tx_full handshake, so the debug unit no longer handles the wide vector directly.

---
 rtl/debug_frame_sender_if.sv | 10 +
 rtl/debug_frame_sender.sv | 109 ++++++++++
 tb/tb_debug_frame_sender.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/debug_frame_sender_if.sv
// Byte-wide write handshake between the frame sender and the UART TX FIFO.
// The sender drives wr/w_data; the FIFO returns its full flag.
interface debug_frame_sender_if;
  logic       wr;
  logic [7:0] w_data;
  logic       tx_full;

  modport master (output wr, output w_data, input tx_full);
  modport slave  (input wr, input w_data, output tx_full);
endinterface

// File: rtl/debug_frame_sender.sv
// Snapshots the MIPS_DLX debug vector on start and streams it to the UART TX FIFO
// as a frame: HEADER, data bytes LSB-first, XOR checksum of the data bytes, TRAILER.
module debug_frame_sender #(
  parameter int         DEBUG_W = 322,
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter logic [7:0] TRAILER = 8'h5A
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DEBUG_W-1:0]  debug_signal,
  debug_frame_sender_if.master fifo,
  output logic                busy,
  output logic                done
);

  localparam int NBYTES = (DEBUG_W + 7) / 8;
  localparam int SNAP_W = NBYTES * 8;
  // Index must also hold NBYTES after the final increment, so it never wraps.
  localparam int IDX_W  = $clog2(NBYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CHK,
    TRL,
    FIN
  } state_t;

  state_t                  state;
  state_t                  state_n;
  logic [IDX_W-1:0]        idx;
  logic [7:0]              chk;
  logic [NBYTES-1:0][7:0]  snap;
  logic [7:0]              byte_out;
  logic                    wr_int;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    byte_out = 8'h00;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = HDR;
      end
      HDR: begin
        busy     = 1'b1;
        byte_out = HEADER;
        if (!fifo.tx_full) state_n = DATA;
      end
      DATA: begin
        busy     = 1'b1;
        byte_out = snap[idx];
        if (!fifo.tx_full && (idx == LAST_IDX)) state_n = CHK;
      end
      CHK: begin
        busy     = 1'b1;
        byte_out = chk;
        if (!fifo.tx_full) state_n = TRL;
      end
      TRL: begin
        busy     = 1'b1;
        byte_out = TRAILER;
        if (!fifo.tx_full) state_n = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // busy is exactly the set of byte-emitting states, so it doubles as the write qualifier.
  assign wr_int      = busy && !fifo.tx_full;
  assign fifo.wr     = wr_int;
  assign fifo.w_data = byte_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      idx  <= '0;
      chk  <= '0;
      snap <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        snap <= SNAP_W'(debug_signal);
        idx  <= '0;
        chk  <= '0;
      end else if ((state == DATA) && wr_int) begin
        chk <= chk ^ byte_out;
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_debug_frame_sender.sv
// Scoreboard bench for debug_frame_sender: expected frame bytes are queued at start
// and compared against every FIFO write; timing, reset and ignored-start cases checked.
module tb_debug_frame_sender;

  localparam int         DEBUG_W = 322;
  localparam logic [7:0] HEADER  = 8'hA5;
  localparam logic [7:0] TRAILER = 8'h5A;
  localparam int         NBYTES  = (DEBUG_W + 7) / 8;
  localparam int         FLEN    = NBYTES + 3;

  logic               clk;
  logic               reset;
  logic               start;
  logic [DEBUG_W-1:0] debug_signal;
  logic               busy;
  logic               done;

  debug_frame_sender_if fifo_if ();

  debug_frame_sender #(
    .DEBUG_W (DEBUG_W),
    .HEADER  (HEADER),
    .TRAILER (TRAILER)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .debug_signal (debug_signal),
    .fifo         (fifo_if.master),
    .busy         (busy),
    .done         (done)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         wr_count = 0;
  int         done_count = 0;
  bit         alt_full = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO full flag: either held low or toggled every cycle.
  initial begin
    fifo_if.tx_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      fifo_if.tx_full = alt_full ? ~fifo_if.tx_full : 1'b0;
    end
  end

  // Monitor: every accepted write is checked against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (done) done_count++;
      if (fifo_if.wr) begin
        wr_count++;
        check("wr_while_full", fifo_if.tx_full, 1'b0);
        if (exp_q.size() == 0) begin
          check("extra_write", fifo_if.wr, 1'b0);
        end else begin
          check("frame_byte", fifo_if.w_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic push_frame(input logic [DEBUG_W-1:0] v);
    logic [NBYTES*8-1:0] p;
    logic [7:0]          b;
    logic [7:0]          c;
    p = '0;
    p[DEBUG_W-1:0] = v;
    c = 8'h00;
    exp_q.push_back(HEADER);
    for (int i = 0; i < NBYTES; i++) begin
      b = p[i*8 +: 8];
      c = c ^ b;
      exp_q.push_back(b);
    end
    exp_q.push_back(c);
    exp_q.push_back(TRAILER);
  endtask

  task automatic run_frame(input logic [DEBUG_W-1:0] v, input bit alt, input int chg_at,
                           input bit extra_starts);
    int n, first, last, done_n, w0, d0;
    alt_full     = alt;
    debug_signal = v;
    push_frame(v);
    w0 = wr_count;
    d0 = done_count;
    first  = -1;
    last   = -1;
    done_n = -1;
    n      = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    while (done_n < 0) begin
      @(posedge clk);
      #1;
      n++;
      start = extra_starts && (n == 3);
      if (n == chg_at) debug_signal = '1;
      @(negedge clk);
      if (fifo_if.wr) begin
        if (first < 0) first = n;
        last = n;
      end
      if (n == 1) check("busy_after_start", busy, 1'b1);
      if (done) done_n = n;
      else if (n > 400) begin
        check("frame_timeout", done, 1'b1);
        done_n = 0;
      end
    end
    if (!alt) begin
      check("first_wr_cycle", first, 1);
      check("last_wr_cycle", last, NBYTES + 3);
      check("done_cycle", done_n, NBYTES + 4);
    end else begin
      check("alt_wr_span", last - first, 2 * (FLEN - 1));
      check("alt_done_cycle", done_n, last + 1);
    end
    check("busy_in_fin", busy, 1'b0);
    if (extra_starts) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
    check("frame_len", wr_count - w0, FLEN);
    check("done_pulses", done_count - d0, 1);
    check("queue_drained", exp_q.size(), 0);
    if (extra_starts) begin
      repeat (20) @(negedge clk);
      check("no_second_frame", wr_count - w0, FLEN);
      check("idle_after_fin_start", busy, 1'b0);
    end
    alt_full = 1'b0;
  endtask

  task automatic run_abort(input logic [DEBUG_W-1:0] v);
    int w0, d0, n;
    debug_signal = v;
    push_frame(v);
    w0 = wr_count;
    d0 = done_count;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while ((wr_count - w0 < 20) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_byte20", (wr_count - w0 >= 20), 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_wr_low", fifo_if.wr, 1'b0);
    check("abort_busy_low", busy, 1'b0);
    exp_q.delete();
    w0 = wr_count;
    repeat (60) @(negedge clk);
    check("abort_no_done", done_count - d0, 0);
    check("abort_no_writes", wr_count - w0, 0);
  endtask

  logic [351:0]       rnd;
  logic [DEBUG_W-1:0] vec;

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    debug_signal = '0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rst_wr", fifo_if.wr, 1'b0);
    check("rst_w_data", fifo_if.w_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    repeat (3) @(negedge clk);
    check("start_with_reset_ignored", busy, 1'b0);
    check("start_with_reset_no_wr", wr_count, 0);

    run_frame('0, 1'b0, -1, 1'b0);

    vec = '0;
    vec[15:0] = 16'h1234;
    run_frame(vec, 1'b0, -1, 1'b0);
    run_frame(vec, 1'b1, -1, 1'b0);

    for (int i = 0; i < 11; i++) rnd[i*32 +: 32] = $urandom;
    vec = rnd[DEBUG_W-1:0];
    vec[DEBUG_W-1] = 1'b1;
    run_frame(vec, 1'b0, 5, 1'b0);

    run_abort(vec);
    vec = ~vec;
    run_frame(vec, 1'b0, -1, 1'b0);

    vec = '1;
    run_frame(vec, 1'b0, -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
